div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 116 +++++++++++
 tb/tb_div_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider.
// A divide is accepted in IDLE, takes WIDTH RUN cycles (one quotient bit per
// cycle) and reports the result with a one-cycle done pulse in DONE.
// A zero divisor skips RUN and reports all-ones / dividend straight away.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;

  // One restoring step: shift the next dividend bit into the partial
  // remainder (kept one bit wider so large divisors cannot overflow it),
  // trial-subtract the divisor and keep or restore depending on the borrow.
  // The dividend register shifts left and collects quotient bits at the LSB.
  always_comb begin
    shifted_rem = {rem_q, dvd_q[WIDTH-1]};
    trial       = shifted_rem - {1'b0, dvs_q};
    borrow      = trial[WIDTH];
    next_rem    = borrow ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
    next_quo    = {dvd_q[WIDTH-2:0], ~borrow};
  end

  // Sequencer: captures operands, iterates, and registers results on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              count <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          dvd_q <= next_quo;
          rem_q <= next_rem;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= next_quo;
            remainder   <= next_rem;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline while a divide is being accepted or iterating; DONE
  // lets it advance so the result is consumed in that cycle.
  always_comb begin
    stall = ((state == IDLE) && start) || (state == RUN);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq (WIDTH=32): basic, zero divisor, extremes,
// ignored start during RUN, reset abort, and back-to-back divides.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int testsRun    = 0;
  int testsFailed = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net in case the stimulus itself stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present a divide request for one cycle, then scramble the operands so a
  // design that fails to capture them produces a wrong result.
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    #1;
    checkOutput("stall_on_start", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0;
  endtask

  // Run one divide and check latency, stall length, result and pulse width.
  // Edges are counted from the accepting edge inclusive.
  task automatic runDivide(input string label, input logic [31:0] dvd,
                           input logic [31:0] dvs, input logic [31:0] expQ,
                           input logic [31:0] expR, input logic expDbz,
                           input int expEdges, input bit inject,
                           input logic [31:0] prevQ);
    int edges;
    int stallCycles;
    bit seen;
    applyStimulus(dvd, dvs);
    edges       = 1;
    stallCycles = 1;
    seen        = 1'b0;
    while (edges < 100 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (stall) stallCycles++;
        if (edges == 2) checkOutput({label, "_quotient_hold"}, quotient, prevQ);
        if (inject && edges == 5) begin
          start    = 1'b1;
          dividend = 32'd50;
          divisor  = 32'd5;
        end else if (inject && edges == 6) begin
          start    = 1'b0;
          dividend = 32'hDEAD_BEEF;
          divisor  = 32'h0;
        end
        @(posedge clk);
        #1;
        edges++;
      end
    end
    checkOutput({label, "_done_edges"}, edges, expEdges);
    checkOutput({label, "_stall_cycles"}, stallCycles, expEdges);
    checkOutput({label, "_stall_in_done"}, 32'(stall), 32'd0);
    checkOutput({label, "_busy_in_done"}, 32'(busy), 32'd1);
    checkOutput({label, "_quotient"}, quotient, expQ);
    checkOutput({label, "_remainder"}, remainder, expR);
    checkOutput({label, "_div_by_zero"}, 32'(div_by_zero), 32'(expDbz));
    @(posedge clk);
    #1;
    checkOutput({label, "_done_single"}, 32'(done), 32'd0);
    checkOutput({label, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({label, "_quotient_kept"}, quotient, expQ);
  endtask

  // Directed sequence.
  initial begin
    int donePulses;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'h0;
    divisor  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runDivide("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0, 32'd0);
    runDivide("b2b", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33, 1'b0, 32'd14);
    runDivide("divzero", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 1'b0, 32'd3);
    runDivide("max_by_one", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0,
              32'hFFFF_FFFF);
    runDivide("small", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33, 1'b0, 32'hFFFF_FFFF);
    runDivide("wide", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 1'b0,
              32'd0);
    runDivide("ignored", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1, 32'd1);

    // Abort a divide with reset in its tenth RUN cycle.
    applyStimulus(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_stall", 32'(stall), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    checkOutput("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    donePulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) donePulses++;
    end
    checkOutput("abort_no_done", donePulses, 32'd0);
    checkOutput("abort_idle", 32'(busy), 32'd0);

    runDivide("after_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
